// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its long-result FIFO.
package wb_pkg;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] word_t;

    localparam reg_idx_t REG_ZERO = '0;

    typedef struct packed {
        reg_idx_t addr;
        word_t    data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; push and pop may coincide.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  wb_req_t         wdata_i,
    input  logic            pop_i,
    output wb_req_t         rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    wb_req_t         mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port,
// and tracks registers still owed a long-latency result.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alu_valid_i,
    input  logic [AW-1:0]            alu_addr_i,
    input  logic [DW-1:0]            alu_data_i,
    input  logic                     lng_valid_i,
    output logic                     lng_ready_o,
    input  logic [AW-1:0]            lng_addr_i,
    input  logic [DW-1:0]            lng_data_i,
    input  logic                     iss_valid_i,
    input  logic [AW-1:0]            iss_addr_i,
    input  logic [AW-1:0]            rs_addr_i,
    input  logic [AW-1:0]            rt_addr_i,
    output logic                     rs_busy_o,
    output logic                     rt_busy_o,
    output logic                     RegWrite_o,
    output logic [AW-1:0]            RDaddr_o,
    output logic [DW-1:0]            RDdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    import wb_pkg::*;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    wb_req_t       fifo_wdata;
    wb_req_t       fifo_head;
    logic          alu_take;

    logic [31:0]   pending_q;
    logic [31:0]   pending_d;
    logic          reg_write_q;
    logic          reg_write_d;
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] rd_addr_d;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    assign lng_ready_o = !fifo_full && !rst_i;
    // Results for r0 complete the handshake but are never queued.
    assign fifo_push   = lng_valid_i && lng_ready_o && (lng_addr_i != REG_ZERO);
    assign alu_take    = alu_valid_i && (alu_addr_i != REG_ZERO);
    assign fifo_pop    = !alu_take && !fifo_empty && !rst_i;

    assign fifo_wdata.addr = lng_addr_i;
    assign fifo_wdata.data = lng_data_i;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    always_comb begin
        reg_write_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        pending_d   = pending_q;

        if (alu_take) begin
            reg_write_d = 1'b1;
            rd_addr_d   = alu_addr_i;
            rd_data_d   = alu_data_i;
        end else if (fifo_pop) begin
            reg_write_d = 1'b1;
            rd_addr_d   = fifo_head.addr;
            rd_data_d   = fifo_head.data;
        end

        // Clear before set so a same-edge re-issue keeps the bit.
        if (fifo_pop) pending_d[fifo_head.addr] = 1'b0;
        if (iss_valid_i && (iss_addr_i != REG_ZERO)) pending_d[iss_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            pending_q   <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
            pending_q   <= pending_d;
        end
    end

    assign RegWrite_o = reg_write_q;
    assign RDaddr_o   = rd_addr_q;
    assign RDdata_o   = rd_data_q;
    assign rs_busy_o  = pending_q[rs_addr_i];
    assign rt_busy_o  = pending_q[rt_addr_i];

endmodule

// File: tb/tb_wb_arbiter.sv
// Scenario bench for wb_arbiter with a queue-based reference model.
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [4:0]    alu_addr;
    logic [31:0]   alu_data;
    logic          lng_valid;
    logic          lng_ready;
    logic [4:0]    lng_addr;
    logic [31:0]   lng_data;
    logic          iss_valid;
    logic [4:0]    iss_addr;
    logic [4:0]    rs_addr;
    logic [4:0]    rt_addr;
    logic          rs_busy;
    logic          rt_busy;
    logic          reg_write;
    logic [4:0]    rd_addr;
    logic [31:0]   rd_data;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DEPTH (DEPTH),
        .DW    (32),
        .AW    (5)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .alu_valid_i (alu_valid),
        .alu_addr_i  (alu_addr),
        .alu_data_i  (alu_data),
        .lng_valid_i (lng_valid),
        .lng_ready_o (lng_ready),
        .lng_addr_i  (lng_addr),
        .lng_data_i  (lng_data),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .rs_addr_i   (rs_addr),
        .rt_addr_i   (rt_addr),
        .rs_busy_o   (rs_busy),
        .rt_busy_o   (rt_busy),
        .RegWrite_o  (reg_write),
        .RDaddr_o    (rd_addr),
        .RDdata_o    (rd_data),
        .count_o     (count)
    );

    // Reference model: a plain queue of owed writes and a set of pending registers.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          mpend[32];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic idle();
        alu_valid = 1'b0;
        lng_valid = 1'b0;
        iss_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        lng_addr  = '0;
        lng_data  = '0;
        iss_addr  = '0;
    endtask

    // Advance the model by one edge using the currently driven inputs, then the DUT.
    task automatic tick();
        ent_t e;
        bit   acc;
        if (rst) begin
            mq.delete();
            foreach (mpend[i]) mpend[i] = 1'b0;
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            acc = lng_valid && (mq.size() < DEPTH);
            if (alu_valid && alu_addr != 0) begin
                m_we   = 1'b1;
                m_addr = alu_addr;
                m_data = alu_data;
            end else if (mq.size() > 0) begin
                e      = mq.pop_front();
                m_we   = 1'b1;
                m_addr = e.a;
                m_data = e.d;
                mpend[e.a] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (iss_valid && iss_addr != 0) mpend[iss_addr] = 1'b1;
            if (acc && lng_addr != 0) mq.push_back(ent_t'{lng_addr, lng_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rs_addr = 5'd3;
        rt_addr = 5'd9;
        tick();
        tick();
        checks++;
        if (lng_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_forced: got %0b want 0", lng_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (reg_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_regwrite: got %0b want 0", reg_write);
        end
        checks++;
        if (rd_addr !== 5'd0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rd: got %0h/%0h want 0/0", rd_addr, rd_data);
        end
        checks++;
        if (count !== '0 || lng_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: got count %0d ready %0b want 0/1", count, lng_ready);
        end
        checks++;
        if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b%0b want 00", rs_busy, rt_busy);
        end
    endtask

    task automatic test_single_long();
        rs_addr   = 5'd8;
        rt_addr   = 5'd0;
        iss_valid = 1'b1;
        iss_addr  = 5'd8;
        tick();
        iss_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (rs_busy !== (c <= 4)) begin
                errors++;
                $display("FAIL single_busy c%0d: got %0b want %0b", c, rs_busy, (c <= 4));
            end
            checks++;
            if (reg_write !== (c == 5)) begin
                errors++;
                $display("FAIL single_we c%0d: got %0b want %0b", c, reg_write, (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (rd_addr !== 5'd8 || rd_data !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL single_wdata: got %0h/%0h want 8/deadbeef", rd_addr, rd_data);
                end
            end
            if (c == 3) begin
                lng_valid = 1'b1;
                lng_addr  = 5'd8;
                lng_data  = 32'hDEADBEEF;
            end
            tick();
            lng_valid = 1'b0;
        end
    endtask

    task automatic test_alu_priority();
        logic [4:0] exp_a;
        for (int c = 0; c <= 5; c++) begin
            if (c >= 1) begin
                exp_a = (c <= 3) ? 5'(c) : 5'd9;
                checks++;
                if (reg_write !== (c <= 4)) begin
                    errors++;
                    $display("FAIL prio_we c%0d: got %0b want %0b", c, reg_write, (c <= 4));
                end else if (c <= 4 && (rd_addr !== exp_a || rd_data !== 32'(exp_a))) begin
                    errors++;
                    $display("FAIL prio_order c%0d: got %0h/%0h want %0h", c, rd_addr, rd_data,
                             exp_a);
                end
            end
            if (c < 5) begin
                alu_valid = (c <= 2);
                alu_addr  = 5'(c + 1);
                alu_data  = 32'(c + 1);
                lng_valid = (c == 0);
                lng_addr  = 5'd9;
                lng_data  = 32'd9;
                tick();
            end
        end
        idle();
    endtask

    task automatic test_full();
        alu_valid = 1'b1;
        lng_valid = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            alu_addr = 5'($urandom_range(1, 31));
            alu_data = $urandom;
            lng_addr = 5'(16 + k);
            lng_data = 32'(32'h100 + k);
            checks++;
            if (lng_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_ready_fill k%0d: got %0b want 1", k, lng_ready);
            end
            tick();
        end
        checks++;
        if (count !== CW'(DEPTH) || lng_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_reached: got count %0d ready %0b want 4/0", count, lng_ready);
        end
        lng_addr = 5'd20;
        lng_data = 32'h104;
        alu_addr = 5'd1;
        tick();
        checks++;
        if (count !== CW'(DEPTH) || reg_write !== 1'b1 || rd_addr !== 5'd1) begin
            errors++;
            $display("FAIL full_hold: got count %0d we %0b addr %0h want 4/1/1", count,
                     reg_write, rd_addr);
        end
        alu_valid = 1'b0;
        tick();
        checks++;
        if (count !== CW'(DEPTH - 1) || lng_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_one_pop: got count %0d ready %0b want 3/1", count, lng_ready);
        end
        checks++;
        if (reg_write !== 1'b1 || rd_addr !== 5'd16 || rd_data !== 32'h100) begin
            errors++;
            $display("FAIL full_pop_data: got %0b %0h/%0h want 1 10/100", reg_write, rd_addr,
                     rd_data);
        end
        alu_valid = 1'b1;
        tick();
        checks++;
        if (count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL full_refill: got %0d want 4", count);
        end
        idle();
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick();
            checks++;
            if (reg_write !== 1'b1 || rd_addr !== 5'(17 + i) || rd_data !== 32'(32'h101 + i)) begin
                errors++;
                $display("FAIL full_drain i%0d: got %0b %0h/%0h want 1 %0h/%0h", i, reg_write,
                         rd_addr, rd_data, 17 + i, 32'h101 + i);
            end
        end
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL full_empty: got %0d want 0", count);
        end
    endtask

    task automatic test_reg_zero();
        lng_valid = 1'b1;
        lng_addr  = 5'd7;
        lng_data  = 32'h77;
        tick();
        alu_valid = 1'b1;
        alu_addr  = 5'd0;
        alu_data  = 32'h55;
        lng_addr  = 5'd0;
        lng_data  = 32'h66;
        iss_valid = 1'b1;
        iss_addr  = 5'd0;
        tick();
        checks++;
        if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h77 || count !== '0) begin
            errors++;
            $display("FAIL r0_drain: got %0b %0h/%0h count %0d want 1 7/77 0", reg_write,
                     rd_addr, rd_data, count);
        end
        tick();
        checks++;
        if (reg_write !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL r0_nowrite: got we %0b count %0d want 0/0", reg_write, count);
        end
        checks++;
        if (rd_addr !== 5'd7 || rd_data !== 32'h77) begin
            errors++;
            $display("FAIL r0_hold: got %0h/%0h want 7/77", rd_addr, rd_data);
        end
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #1;
        checks++;
        if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
            errors++;
            $display("FAIL r0_busy: got %0b%0b want 00", rs_busy, rt_busy);
        end
        idle();
    endtask

    task automatic test_collision();
        rs_addr   = 5'd4;
        iss_valid = 1'b1;
        iss_addr  = 5'd4;
        tick();
        iss_valid = 1'b0;
        lng_valid = 1'b1;
        lng_addr  = 5'd4;
        lng_data  = 32'h44;
        tick();
        lng_valid = 1'b0;
        iss_valid = 1'b1;
        tick();
        iss_valid = 1'b0;
        checks++;
        if (reg_write !== 1'b1 || rd_addr !== 5'd4 || rd_data !== 32'h44) begin
            errors++;
            $display("FAIL coll_write: got %0b %0h/%0h want 1 4/44", reg_write, rd_addr, rd_data);
        end
        checks++;
        if (rs_busy !== 1'b1) begin
            errors++;
            $display("FAIL coll_set_wins: got %0b want 1", rs_busy);
        end
        tick();
        checks++;
        if (rs_busy !== 1'b1) begin
            errors++;
            $display("FAIL coll_persist: got %0b want 1", rs_busy);
        end
    endtask

    task automatic test_reset_mid();
        rs_addr   = 5'd4;
        rt_addr   = 5'd5;
        iss_valid = 1'b1;
        iss_addr  = 5'd5;
        tick();
        iss_valid = 1'b0;
        alu_valid = 1'b1;
        lng_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            alu_addr = 5'($urandom_range(1, 31));
            alu_data = $urandom;
            lng_addr = 5'(10 + k);
            lng_data = $urandom;
            tick();
        end
        checks++;
        if (count !== CW'(3) || rs_busy !== 1'b1 || rt_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got count %0d busy %0b%0b want 3 11", count, rs_busy,
                     rt_busy);
        end
        rst       = 1'b1;
        iss_valid = 1'b1;
        iss_addr  = 5'd6;
        lng_addr  = 5'd13;
        tick();
        checks++;
        if (count !== '0 || reg_write !== 1'b0 || lng_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got count %0d we %0b ready %0b want 0/0/0", count,
                     reg_write, lng_ready);
        end
        checks++;
        if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: got %0b%0b want 00", rs_busy, rt_busy);
        end
        rst = 1'b0;
        idle();
        rs_addr = 5'd6;
        #1;
        checks++;
        if (rs_busy !== 1'b0 || lng_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ignored: got busy %0b ready %0b want 0/1", rs_busy, lng_ready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_addr  = 5'($urandom);
            alu_data  = $urandom;
            lng_valid = $urandom_range(0, 1) == 1;
            lng_addr  = 5'($urandom);
            lng_data  = $urandom;
            iss_valid = $urandom_range(0, 1) == 1;
            iss_addr  = 5'($urandom);
            rs_addr   = 5'($urandom);
            rt_addr   = 5'($urandom);
            #1;
            checks++;
            if (lng_ready !== (!rst && mq.size() < DEPTH)) begin
                errors++;
                $display("FAIL rnd_ready i%0d: got %0b want %0b", i, lng_ready,
                         (!rst && mq.size() < DEPTH));
            end
            checks++;
            if (rs_busy !== mpend[rs_addr] || rt_busy !== mpend[rt_addr]) begin
                errors++;
                $display("FAIL rnd_busy i%0d: got %0b%0b want %0b%0b", i, rs_busy, rt_busy,
                         mpend[rs_addr], mpend[rt_addr]);
            end
            tick();
            checks++;
            if (reg_write !== m_we || rd_addr !== m_addr || rd_data !== m_data) begin
                errors++;
                $display("FAIL rnd_out i%0d: got %0b %0h/%0h want %0b %0h/%0h", i, reg_write,
                         rd_addr, rd_data, m_we, m_addr, m_data);
            end
            checks++;
            if (count !== CW'(mq.size())) begin
                errors++;
                $display("FAIL rnd_count i%0d: got %0d want %0d", i, count, mq.size());
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        rs_addr = '0;
        rt_addr = '0;
        idle();
        test_reset();
        test_single_long();
        test_alu_priority();
        test_full();
        test_reg_zero();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
